// File: rtl/logic_accum_unit_if.sv
// Operand/result handshake bundle for logic_accum_unit.
// The parity signal exists only when LOGIC_ACCUM_PARITY_EN is defined.
interface logic_accum_unit_if #(
  parameter int W         = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic          acc_mode;
  logic          last;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          any;
  logic [CW-1:0] count;
  logic          ovf;
`ifdef LOGIC_ACCUM_PARITY_EN
  logic          parity;

  modport master (
    output in_valid, op, acc_mode, last, a, b, out_ready,
    input  in_ready, out_valid, y, any, count, ovf, parity
  );
  modport slave (
    input  in_valid, op, acc_mode, last, a, b, out_ready,
    output in_ready, out_valid, y, any, count, ovf, parity
  );
`else
  modport master (
    output in_valid, op, acc_mode, last, a, b, out_ready,
    input  in_ready, out_valid, y, any, count, ovf
  );
  modport slave (
    input  in_valid, op, acc_mode, last, a, b, out_ready,
    output in_ready, out_valid, y, any, count, ovf
  );
`endif
endinterface

// File: rtl/logic_accum_unit.sv
// Registered W-bit AND/OR/XOR/NOR unit with pair mode and multi-beat accumulate mode.
// Optional parity output is enabled with the LOGIC_ACCUM_PARITY_EN macro.
module logic_accum_unit #(
  parameter int W         = 8,
  parameter int MAX_BEATS = 16
) (
  input logic             clk,
  input logic             rst,
  logic_accum_unit_if.slave bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t        state, state_next;
  logic [W-1:0]  acc, acc_next;
  logic [CW-1:0] beats, beats_next;
  logic [1:0]    lop, lop_next;

  logic          accept;
  logic          in_ready;
  logic          load;
  logic [W-1:0]  res_y;
  logic [CW-1:0] res_count;
  logic          res_ovf;
  logic [W-1:0]  acc_sum;
  logic [CW-1:0] beat_sum;
  logic          hit_max;

  logic          out_valid_q;
  logic [W-1:0]  y_q;
  logic          any_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  function automatic logic [W-1:0] ident(input logic [1:0] f_op);
    return (f_op == 2'b00) ? {W{1'b1}} : {W{1'b0}};
  endfunction

  // NOR accumulates as OR; the inversion happens once when the packet closes.
  function automatic logic [W-1:0] fold(input logic [1:0] f_op, input logic [W-1:0] x,
                                        input logic [W-1:0] v);
    case (f_op)
      2'b00:   return x & v;
      2'b10:   return x ^ v;
      default: return x | v;
    endcase
  endfunction

  function automatic logic [W-1:0] finish(input logic [1:0] f_op, input logic [W-1:0] x);
    return (f_op == 2'b11) ? ~x : x;
  endfunction

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  // Next-state logic and the result to load into the output register.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    beats_next = beats;
    lop_next   = lop;
    load       = 1'b0;
    res_y      = '0;
    res_count  = '0;
    res_ovf    = 1'b0;
    acc_sum    = fold(lop, acc, bus.a);
    beat_sum   = beats + CW'(1);
    hit_max    = (beat_sum == CW'(MAX_BEATS));
    if (accept) begin
      case (state)
        IDLE: begin
          if (!bus.acc_mode) begin
            load      = 1'b1;
            res_count = CW'(1);
            case (bus.op)
              2'b00: res_y = bus.a & bus.b;
              2'b01: res_y = bus.a | bus.b;
              2'b10: res_y = bus.a ^ bus.b;
              2'b11: res_y = ~(bus.a | bus.b);
            endcase
          end else if (bus.last) begin
            load      = 1'b1;
            res_count = CW'(1);
            res_y     = finish(bus.op, fold(bus.op, ident(bus.op), bus.a));
          end else begin
            lop_next   = bus.op;
            acc_next   = fold(bus.op, ident(bus.op), bus.a);
            beats_next = CW'(1);
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (bus.last || hit_max) begin
            load       = 1'b1;
            res_y      = finish(lop, acc_sum);
            res_count  = beat_sum;
            res_ovf    = hit_max & ~bus.last;
            acc_next   = '0;
            beats_next = '0;
            state_next = IDLE;
          end else begin
            acc_next   = acc_sum;
            beats_next = beat_sum;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      beats <= '0;
      lop   <= 2'b00;
    end else begin
      acc   <= acc_next;
      beats <= beats_next;
      lop   <= lop_next;
    end
  end

  // A fresh result wins over a same-edge consume, so out_valid stays high on a swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      any_q       <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      y_q         <= res_y;
      any_q       <= |res_y;
      count_q     <= res_count;
      ovf_q       <= res_ovf;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef LOGIC_ACCUM_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst)       parity_q <= 1'b0;
    else if (load) parity_q <= ^res_y;
  end

  assign bus.parity = parity_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.any       = any_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_logic_accum_unit.sv
// Self-checking bench for logic_accum_unit: packet-level reference model with
// a per-cycle compare process, directed literal checks, then random traffic.
module tb_logic_accum_unit;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic_accum_unit_if #(.W(W), .MAX_BEATS(MB)) bus ();

  logic_accum_unit #(.W(W), .MAX_BEATS(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: output register contents plus the open packet's beats.
  logic          m_known = 1'b0;
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_y     = '0;
  logic [CW-1:0] m_count = '0;
  logic          m_ovf   = 1'b0;
  logic          pkt_open = 1'b0;
  logic [1:0]    pkt_op  = 2'b00;
  logic [W-1:0]  pkt[$];
  logic          take;
  logic          produced;
  logic [W-1:0]  r_y;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  function automatic logic [W-1:0] pair_result(input logic [1:0] f_op, input logic [W-1:0] x,
                                               input logic [W-1:0] v);
    case (f_op)
      2'b00:   return x & v;
      2'b01:   return x | v;
      2'b10:   return x ^ v;
      default: return ~(x | v);
    endcase
  endfunction

  function automatic logic [W-1:0] packet_result(input logic [1:0] f_op);
    logic [W-1:0] r;
    r = (f_op == 2'b00) ? {W{1'b1}} : {W{1'b0}};
    foreach (pkt[i]) begin
      case (f_op)
        2'b00:   r = r & pkt[i];
        2'b10:   r = r ^ pkt[i];
        default: r = r | pkt[i];
      endcase
    end
    return (f_op == 2'b11) ? ~r : r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_known  = 1'b1;
      m_valid  = 1'b0;
      m_y      = '0;
      m_count  = '0;
      m_ovf    = 1'b0;
      pkt_open = 1'b0;
      pkt.delete();
    end else if (m_known) begin
      take     = bus.in_valid && (!m_valid || bus.out_ready);
      produced = 1'b0;
      r_y      = '0;
      r_cnt    = '0;
      r_ovf    = 1'b0;
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (take) begin
        if (!pkt_open && !bus.acc_mode) begin
          r_y      = pair_result(bus.op, bus.a, bus.b);
          r_cnt    = CW'(1);
          produced = 1'b1;
        end else begin
          if (!pkt_open) pkt_op = bus.op;
          pkt.push_back(bus.a);
          if (bus.last || pkt.size() == MB) begin
            r_y      = packet_result(pkt_op);
            r_cnt    = CW'(pkt.size());
            r_ovf    = !bus.last;
            produced = 1'b1;
            pkt_open = 1'b0;
            pkt.delete();
          end else begin
            pkt_open = 1'b1;
          end
        end
      end
      if (produced) begin
        m_valid = 1'b1;
        m_y     = r_y;
        m_count = r_cnt;
        m_ovf   = r_ovf;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      cmp("model.out_valid", 32'(bus.out_valid), 32'(m_valid));
      cmp("model.in_ready",  32'(bus.in_ready),  32'(!m_valid || bus.out_ready));
      cmp("model.y",         32'(bus.y),         32'(m_y));
      cmp("model.any",       32'(bus.any),       32'(|m_y));
      cmp("model.count",     32'(bus.count),     32'(m_count));
      cmp("model.ovf",       32'(bus.ovf),       32'(m_ovf));
`ifdef LOGIC_ACCUM_PARITY_EN
      cmp("model.parity",    32'(bus.parity),    32'(^m_y));
`endif
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] o, input logic am, input logic l,
                               input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ordy);
    @(posedge clk);
    #2;
    bus.in_valid  = v;
    bus.op        = o;
    bus.acc_mode  = am;
    bus.last      = l;
    bus.a         = aa;
    bus.b         = bb;
    bus.out_ready = ordy;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic er,
                             input logic [W-1:0] ey, input logic [CW-1:0] ec, input logic eo);
    @(negedge clk);
    cmp({name, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    cmp({name, ".in_ready"},  32'(bus.in_ready),  32'(er));
    cmp({name, ".y"},         32'(bus.y),         32'(ey));
    cmp({name, ".any"},       32'(bus.any),       32'(|ey));
    cmp({name, ".count"},     32'(bus.count),     32'(ec));
    cmp({name, ".ovf"},       32'(bus.ovf),       32'(eo));
  endtask

  logic [W-1:0] vals [4];
  logic [W-1:0] truth;

  initial begin
    vals = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.acc_mode  = 1'b0;
    bus.last      = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    checkOutput("reset", 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);

    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b1);
    idle();
    checkOutput("pair_or", 1'b1, 1'b1, 8'hFF, 3'd1, 1'b0);

    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          case (o)
            0:       truth = vals[i] & vals[j];
            1:       truth = vals[i] | vals[j];
            2:       truth = vals[i] ^ vals[j];
            default: truth = ~(vals[i] | vals[j]);
          endcase
          applyStimulus(1'b1, 2'(o), 1'b0, 1'b0, vals[i], vals[j], 1'b1);
          idle();
          checkOutput("pair_truth", 1'b1, 1'b1, truth, 3'd1, 1'b0);
        end
      end
    end

    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 8'hF7, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 8'h7F, 8'h00, 1'b1);
    idle();
    checkOutput("acc_and", 1'b1, 1'b1, 8'h77, 3'd3, 1'b0);

    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 8'h02, 8'h00, 1'b1);
    idle();
    checkOutput("acc_nor", 1'b1, 1'b1, 8'hFC, 3'd2, 1'b0);

    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 8'hF0, 8'h00, 1'b1);
    idle();
    checkOutput("acc_xor", 1'b1, 1'b1, 8'h00, 3'd3, 1'b0);

    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 8'h04, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 8'h08, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
    checkOutput("acc_ovf", 1'b1, 1'b1, 8'h0F, 3'd4, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 8'h20, 8'h00, 1'b1);
    idle();
    checkOutput("acc_after_ovf", 1'b1, 1'b1, 8'h30, 3'd2, 1'b0);

    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 8'hAA, 8'hFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 8'h55, 8'hFF, 1'b0);
      checkOutput("bp_hold", 1'b1, 1'b0, 8'hAA, 3'd1, 1'b0);
    end
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 8'h55, 8'hFF, 1'b1);
    checkOutput("bp_release", 1'b1, 1'b1, 8'hAA, 3'd1, 1'b0);
    idle();
    checkOutput("bp_swap", 1'b1, 1'b1, 8'h55, 3'd1, 1'b0);

    idle();
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 8'h22, 8'h00, 1'b1);
    @(posedge clk);
    #2;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    checkOutput("rst_mid", 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 8'h3C, 8'h00, 1'b1);
    idle();
    checkOutput("after_rst", 1'b1, 1'b1, 8'h3C, 3'd1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #2;
      rst           = ($urandom_range(0, 199) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      bus.op        = 2'($urandom_range(0, 3));
      bus.acc_mode  = $urandom_range(0, 1) == 1;
      bus.last      = ($urandom_range(0, 3) == 0);
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk);
    #2;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_accum_unit.md
Name: logic_accum_unit

Overview:
- Parametrised, registered successor to the two-input bitwise gates: W-bit AND/OR/XOR/NOR on operand pairs, plus a multi-beat accumulate mode folding a stream of words into one result.
- valid/ready on input and output; single output register with back-pressure.
- Sits between operand producers and flag/mask consumers in the gates/datapath layer.

Parameters:
- W, 8, operand/result width in bits (W >= 1)
- MAX_BEATS, 16, max beats per accumulate packet before forced close (2..65535)
- CW, $clog2(MAX_BEATS+1), width of beat-count output (derived, do not override)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat offered
- in_ready  out  1  unit accepts beat this cycle
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- acc_mode  in  1  0 = pair mode, 1 = accumulate mode
- last  in  1  final beat of accumulate packet (ignored in pair mode)
- a  in  W  operand A / accumulate data
- b  in  W  operand B (ignored in accumulate mode)
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes result
- y  out  W  result
- any  out  1  OR-reduction of y
- count  out  CW  beats folded into y (1 in pair mode)
- ovf  out  1  packet force-closed at MAX_BEATS

Behaviour:
- Clock clk, reset rst: one clock, synchronous active-high reset.
- Reset: state IDLE, out_valid=0, y=0, any=0, count=0, ovf=0, accumulator=0, beat counter=0, latched op=00. Reset mid-packet discards partial accumulation and any held result.
- Beat accepted when in_valid & in_ready. in_ready = ~out_valid | out_ready, identical in both states (accumulator separate from output register).
- Output: result loads output register on the edge after the closing beat (latency 1). Held stable while out_valid & ~out_ready. out_valid clears on out_valid & out_ready unless a new result loads same edge (then stays 1 with new data).
- States: IDLE (no packet open), ACCUM (packet open).
- IDLE, acc_mode=0: y <= a op b; count <= 1; ovf <= 0; stay IDLE.
- IDLE, acc_mode=1, last=1: single-beat packet; y <= f(ident op a); count <= 1; stay IDLE.
- IDLE, acc_mode=1, last=0: latch op; acc <= ident op a; beats <= 1; go ACCUM.
- ACCUM, any accepted beat: acc_mode and op ignored, latched op used; acc <= acc op' a; beats += 1.
- ACCUM closes on last=1 or when beats reaches MAX_BEATS: y <= f(new acc); count <= new beats; ovf <= 1 only when closed by MAX_BEATS with last=0; go IDLE.
- Identity: AND all-ones; OR, XOR, NOR zero. In accumulate, NOR folds as OR (op'); f inverts final value only for NOR. Pair-mode NOR = ~(a|b).
- any = |y, registered with y.
- No accepted beat in ACCUM: state holds indefinitely (no timeout).
- count saturation impossible: counter closes at MAX_BEATS.

Optional Feature:
- Macro LOGIC_ACCUM_PARITY_EN.
- Defined: extra output port parity (1 bit) = ^y, registered with y, reset 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Pair mode W=8, op=01, a=8'hF0, b=8'h0F, out_ready=1 -> next cycle out_valid=1, y=8'hFF, any=1, count=1, ovf=0; all four ops over a,b in {00,FF,A5,5A} match bitwise truth.
- Accumulate op=00, beats a=FF,F7,7F with last on 3rd -> y=8'h77, count=3, out_valid 1 cycle after 3rd beat; op changed to 10 on beat 2 has no effect.
- Accumulate op=11 beats 01,02 (last) -> y=8'hFC; op=10 beats 0F,FF,F0 (last) -> y=8'h00, any=0.
- MAX_BEATS=4, op=01, 5 beats of 01,02,04,08,10 with no last -> first result y=8'h0F, count=4, ovf=1; 5th beat opens a new packet.
- Back-pressure: out_ready=0 with result held -> in_ready=0, y stable over 5 cycles; raise out_ready with in_valid high -> same-edge swap, out_valid stays 1.
- Assert rst for one cycle mid-packet after 2 beats -> out_valid=0, y=0, count=0; next single-beat packet a=3C op=01 gives y=8'h3C, count=1.
